// File: rtl/life_row_engine_if.sv
// Row-stream bus for the life row engine: one input row stream, one output row stream.
interface life_row_engine_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_row;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_row;
   logic             out_last;

   modport slave (
      input  in_valid, in_row, in_last, out_ready,
      output in_ready, out_valid, out_row, out_last
   );

   modport master (
      output in_valid, in_row, in_last, out_ready,
      input  in_ready, out_valid, out_row, out_last
   );
endinterface

// File: rtl/life_row_engine.sv
// Streaming cellular-automaton row engine: takes a frame row by row and emits the
// next generation of each row once its lower neighbour row has arrived.
module life_row_engine #(
   parameter int         WIDTH   = 8,
   parameter logic [8:0] BIRTH   = 9'b000001000,
   parameter logic [8:0] SURVIVE = 9'b000001100,
   parameter bit         WRAP    = 1'b0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   life_row_engine_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] above_q, above_d;
   logic [WIDTH-1:0] cur_q, cur_d;
   logic [WIDTH-1:0] out_row_q, out_row_d;
   logic             out_last_q, out_last_d;
   logic             out_vld_q, out_vld_d;

   logic             out_free;
   logic             in_ready;
   logic             in_fire;
   logic [WIDTH-1:0] below_row;
   logic [WIDTH-1:0] next_row_w;

   // Rows are extended by one column on each side: index 0 is column -1,
   // index WIDTH+1 is column WIDTH; those edge columns are dead or wrapped.
   function automatic logic [WIDTH+1:0] extend(input logic [WIDTH-1:0] r);
      logic lo, hi;
      lo = WRAP ? r[WIDTH-1] : 1'b0;
      hi = WRAP ? r[0]       : 1'b0;
      extend = {hi, r, lo};
   endfunction

   function automatic logic [WIDTH-1:0] next_gen(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] c,
                                                 input logic [WIDTH-1:0] b);
      logic [WIDTH+1:0] ea, ec, eb;
      logic [3:0]       n;
      next_gen = '0;
      ea = extend(a);
      ec = extend(c);
      eb = extend(b);
      for (int i = 0; i < WIDTH; i++) begin
         n = 4'(ea[i]) + 4'(ea[i+1]) + 4'(ea[i+2])
           + 4'(ec[i])               + 4'(ec[i+2])
           + 4'(eb[i]) + 4'(eb[i+1]) + 4'(eb[i+2]);
         next_gen[i] = c[i] ? SURVIVE[n] : BIRTH[n];
      end
   endfunction

   assign out_free  = !out_vld_q || bus.out_ready;
   assign in_ready  = (state_q != S_FLUSH) && out_free;
   assign in_fire   = bus.in_valid && in_ready;
   // One shared neighbourhood engine: the row below is dead when flushing the bottom row.
   assign below_row = (state_q == S_FLUSH) ? '0 : bus.in_row;
   assign next_row_w = next_gen(above_q, cur_q, below_row);

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_vld_q;
   assign bus.out_row   = out_row_q;
   assign bus.out_last  = out_last_q;

   // Next-state logic: row shifting, output generation and frame sequencing.
   always_comb begin
      state_d    = state_q;
      above_d    = above_q;
      cur_d      = cur_q;
      out_row_d  = out_row_q;
      out_last_d = out_last_q;
      out_vld_d  = out_vld_q && !bus.out_ready;
      case (state_q)
         S_IDLE: begin
            if (in_fire) begin
               cur_d   = bus.in_row;
               above_d = '0;
               state_d = bus.in_last ? S_FLUSH : S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (in_fire) begin
               out_row_d  = next_row_w;
               out_last_d = 1'b0;
               out_vld_d  = 1'b1;
               above_d    = cur_q;
               cur_d      = bus.in_row;
               state_d    = bus.in_last ? S_FLUSH : S_ACTIVE;
            end
         end
         S_FLUSH: begin
            if (out_free) begin
               out_row_d  = next_row_w;
               out_last_d = 1'b1;
               out_vld_d  = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and row registers; reset abandons any partial frame.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         above_q    <= '0;
         cur_q      <= '0;
         out_row_q  <= '0;
         out_last_q <= 1'b0;
         out_vld_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         above_q    <= above_d;
         cur_q      <= cur_d;
         out_row_q  <= out_row_d;
         out_last_q <= out_last_d;
         out_vld_q  <= out_vld_d;
      end
   end

endmodule

// File: tb/tb_life_row_engine.sv
// Directed bench: several engine configurations driven in lockstep from one shared stimulus.
module tb_life_row_engine;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_last;
   logic       out_ready;
   logic [7:0] in_row;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   life_row_engine_if #(.WIDTH(5)) if5  ();
   life_row_engine_if #(.WIDTH(8)) if8  ();
   life_row_engine_if #(.WIDTH(8)) if8w ();
   life_row_engine_if #(.WIDTH(4)) if4  ();
   life_row_engine_if #(.WIDTH(8)) ifhl ();

   assign if5.in_valid  = in_valid;  assign if5.in_last  = in_last;
   assign if5.out_ready = out_ready; assign if5.in_row   = in_row[4:0];
   assign if8.in_valid  = in_valid;  assign if8.in_last  = in_last;
   assign if8.out_ready = out_ready; assign if8.in_row   = in_row;
   assign if8w.in_valid = in_valid;  assign if8w.in_last = in_last;
   assign if8w.out_ready = out_ready; assign if8w.in_row = in_row;
   assign if4.in_valid  = in_valid;  assign if4.in_last  = in_last;
   assign if4.out_ready = out_ready; assign if4.in_row   = in_row[3:0];
   assign ifhl.in_valid = in_valid;  assign ifhl.in_last = in_last;
   assign ifhl.out_ready = out_ready; assign ifhl.in_row = in_row;

   life_row_engine #(.WIDTH(5), .WRAP(1'b0)) u5 (.clk_i(clk), .rst_i(rst), .bus(if5));
   life_row_engine #(.WIDTH(8), .WRAP(1'b0)) u8 (.clk_i(clk), .rst_i(rst), .bus(if8));
   life_row_engine #(.WIDTH(8), .WRAP(1'b1)) u8w (.clk_i(clk), .rst_i(rst), .bus(if8w));
   life_row_engine #(.WIDTH(4), .WRAP(1'b0)) u4 (.clk_i(clk), .rst_i(rst), .bus(if4));
   life_row_engine #(.WIDTH(8), .BIRTH(9'b001001000), .SURVIVE(9'b000001100), .WRAP(1'b0))
      uhl (.clk_i(clk), .rst_i(rst), .bus(ifhl));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input logic [7:0] row, input logic last);
      in_valid = 1'b1;
      in_row   = row;
      in_last  = last;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_row = 8'h00; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset out_valid", if8.out_valid, 0);
      chk("reset out_row",   if8.out_row,   0);
      chk("reset out_last",  if8.out_last,  0);
      chk("reset in_ready",  if8.in_ready,  1);

      // vertical blinker, 5 columns, one output per cycle
      push(8'h00, 1'b0);
      chk("blink5 no output on top row", if5.out_valid, 0);
      push(8'h04, 1'b0);
      chk("blink5 r0 valid", if5.out_valid, 1);
      chk("blink5 r0 row",   if5.out_row,   5'h00);
      chk("blink5 r0 last",  if5.out_last,  0);
      push(8'h04, 1'b0);
      chk("blink5 r1 row", if5.out_row, 5'h00);
      push(8'h04, 1'b0);
      chk("blink5 r2 row", if5.out_row, 5'h0E);
      chk("blink8 r2 row", if8.out_row, 8'h0E);
      push(8'h00, 1'b1);
      chk("blink5 r3 row",  if5.out_row,  5'h00);
      chk("blink5 r3 last", if5.out_last, 0);
      chk("blink5 flush in_ready", if5.in_ready, 0);
      in_valid = 1'b0; in_last = 1'b0;
      tick();
      chk("blink5 r4 valid", if5.out_valid, 1);
      chk("blink5 r4 row",   if5.out_row,   5'h00);
      chk("blink5 r4 last",  if5.out_last,  1);
      tick();
      chk("blink5 idle valid",    if5.out_valid, 0);
      chk("blink5 idle in_ready", if5.in_ready,  1);

      // column-0 blinker: edge dead vs. wrapped
      push(8'h00, 1'b0);
      push(8'h01, 1'b0);
      push(8'h01, 1'b0);
      chk("edge wrap r1 row", if8w.out_row, 8'h00);
      push(8'h01, 1'b0);
      chk("edge nowrap r2 row", if8.out_row,  8'h03);
      chk("edge wrap r2 row",   if8w.out_row, 8'h83);
      push(8'h00, 1'b1);
      in_valid = 1'b0; in_last = 1'b0;
      tick();
      chk("edge r4 last", if8.out_last, 1);
      tick();

      // single-row frame
      push(8'hFF, 1'b1);
      chk("single no output yet", if8.out_valid, 0);
      chk("single in_ready low",  if8.in_ready,  0);
      in_valid = 1'b0; in_last = 1'b0;
      tick();
      chk("single valid",   if8.out_valid, 1);
      chk("single row",     if8.out_row,   8'h7E);
      chk("single last",    if8.out_last,  1);
      chk("single wrap row", if8w.out_row, 8'hFF);
      tick();
      chk("single back idle valid",    if8.out_valid, 0);
      chk("single back idle in_ready", if8.in_ready,  1);

      // backpressure mid-frame
      push(8'h03, 1'b0);
      push(8'h03, 1'b0);
      chk("stall r0 row", if8.out_row, 8'h03);
      push(8'h00, 1'b0);
      chk("stall r1 row", if8.out_row, 8'h03);
      push(8'hC0, 1'b0);
      chk("stall r2 row", if8.out_row, 8'h00);
      out_ready = 1'b0; in_valid = 1'b1; in_row = 8'hC0; in_last = 1'b1;
      #1;
      chk("stall in_ready low", if8.in_ready, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall hold valid",    if8.out_valid, 1);
         chk("stall hold row",      if8.out_row,   8'h00);
         chk("stall hold last",     if8.out_last,  0);
         chk("stall hold in_ready", if8.in_ready,  0);
      end
      out_ready = 1'b1;
      tick();
      chk("stall r3 row",  if8.out_row,  8'hC0);
      chk("stall r3 last", if8.out_last, 0);
      in_valid = 1'b0; in_last = 1'b0;
      tick();
      chk("stall r4 row",  if8.out_row,  8'hC0);
      chk("stall r4 last", if8.out_last, 1);
      tick();
      chk("stall idle valid", if8.out_valid, 0);

      // reset mid-frame, then a 4x4 block frame
      push(8'hFF, 1'b0);
      push(8'hFF, 1'b0);
      chk("abort partial output", if8.out_valid, 1);
      rst = 1'b1; in_valid = 1'b1; in_row = 8'hFF; in_last = 1'b0;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk("abort out_valid cleared", if4.out_valid, 0);
      chk("abort in_ready",          if4.in_ready,  1);
      push(8'h00, 1'b0);
      chk("block top no output", if4.out_valid, 0);
      push(8'h06, 1'b0);
      chk("block r0 row", if4.out_row, 4'h0);
      push(8'h06, 1'b0);
      chk("block r1 row", if4.out_row, 4'h6);
      push(8'h00, 1'b1);
      chk("block r2 row",  if4.out_row,  4'h6);
      chk("block r2 last", if4.out_last, 0);
      in_valid = 1'b0; in_last = 1'b0;
      tick();
      chk("block r3 row",  if4.out_row,  4'h0);
      chk("block r3 last", if4.out_last, 1);
      tick();

      // HighLife birth on six neighbours
      push(8'h07, 1'b0);
      push(8'h00, 1'b0);
      chk("highlife r0 row", ifhl.out_row, 8'h02);
      push(8'h07, 1'b1);
      chk("highlife r1 row", ifhl.out_row, 8'h02);
      chk("life r1 row",     if8.out_row,  8'h00);
      in_valid = 1'b0; in_last = 1'b0;
      tick();
      chk("highlife r2 row",  ifhl.out_row,  8'h02);
      chk("highlife r2 last", ifhl.out_last, 1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
